vga_sync_receiver: RTL

- Sink-side counterpart of the board's VGA timing generator. Consumes active-low H/V sync and 10-bit RGB, recovers line and frame timing, locks onto a stable mode, and emits per-pixel X/Y coordinates with captured colour.
- Used for loopback self-test of the display path and as the front end of a frame-capture path into SDRAM.

---
 rtl/vga_sync_receiver.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/vga_sync_receiver.sv
// -----------------------------------------------------------------------------
// vga_sync_receiver
//
// Sink-side VGA timing recovery. Watches active-low H/V sync, measures line
// length and lines per frame, locks onto a stable mode and emits per-pixel
// X/Y coordinates together with the captured 10-bit RGB sample.
//
// Optional build macro: VGA_SYNC_RECEIVER_STATS_EN
//   Adds oFrame_Cnt (frames received while locked, wrapping) and oErr_Cnt
//   (lock-loss pulses, saturating). Without the macro neither the ports nor
//   the counters exist.
//
// Ports:
//   iCLK          pixel clock
//   iRST_N        synchronous active-low reset
//   iVGA_H_SYNC   horizontal sync, active low
//   iVGA_V_SYNC   vertical sync, active low
//   iVGA_R/G/B    10-bit colour inputs
//   oPix_Valid    captured pixel valid (locked and inside the active window)
//   oX, oY        pixel column / row inside the active window
//   oR/oG/oB      captured colour
//   oFrame_Start  pulse with the first valid pixel of a frame (oX=0, oY=0)
//   oLocked       timing lock
//   oErr          one-cycle pulse on lock loss
//   oLine_Len     last measured line length in clocks
//   oFrame_Lines  last measured lines per frame
//   oFrame_Cnt    (stats build) locked frames received
//   oErr_Cnt      (stats build) lock-loss count
// -----------------------------------------------------------------------------
module vga_sync_receiver #(
  parameter int CNT_W   = 11,
  parameter int X_START = 144,
  parameter int Y_START = 35,
  parameter int H_ACT   = 640,
  parameter int V_ACT   = 480
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic             iVGA_H_SYNC,
  input  logic             iVGA_V_SYNC,
  input  logic [9:0]       iVGA_R,
  input  logic [9:0]       iVGA_G,
  input  logic [9:0]       iVGA_B,
  output logic             oPix_Valid,
  output logic [CNT_W-1:0] oX,
  output logic [CNT_W-1:0] oY,
  output logic [9:0]       oR,
  output logic [9:0]       oG,
  output logic [9:0]       oB,
  output logic             oFrame_Start,
  output logic             oLocked,
  output logic             oErr,
`ifdef VGA_SYNC_RECEIVER_STATS_EN
  output logic [15:0]      oFrame_Cnt,
  output logic [15:0]      oErr_Cnt,
`endif
  output logic [CNT_W-1:0] oLine_Len,
  output logic [CNT_W-1:0] oFrame_Lines
);

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] X_LO      = CNT_W'(X_START);
  localparam logic [CNT_W-1:0] X_HI      = CNT_W'(X_START + H_ACT);
  localparam logic [CNT_W-1:0] Y_LO      = CNT_W'(Y_START);
  localparam logic [CNT_W-1:0] Y_HI      = CNT_W'(Y_START + V_ACT);
  // A frame must at least reach the bottom of the active window to be a mode.
  localparam logic [CNT_W-1:0] MIN_LINES = CNT_W'(Y_START + V_ACT);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t           state, state_next;
  logic             h_prev, v_prev;
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic [CNT_W-1:0] ref_len, ref_len_next;
  logic [CNT_W-1:0] ref_lines, ref_lines_next;
  logic             have_ref, have_ref_next;
  logic             bad, bad_next;

  logic             h_edge, v_edge, h_sat;
  logic [CNT_W-1:0] line_len, frame_lines;
  logic             len_mismatch, lines_mismatch;
  logic             in_window, pix_valid, lock_loss;

  // ---------------------------------------------------------------------------
  // Sync edge detection and measurement arithmetic
  // ---------------------------------------------------------------------------
  assign h_edge         = h_prev & ~iVGA_H_SYNC;
  assign v_edge         = v_prev & ~iVGA_V_SYNC;
  assign h_sat          = (h_cnt == CNT_MAX);
  // h_cnt/v_cnt hold the index of the last clock/line, so lengths are +1.
  assign line_len       = h_cnt + CNT_ONE;
  assign frame_lines    = v_cnt + CNT_ONE;
  assign len_mismatch   = (line_len != ref_len);
  assign lines_mismatch = (frame_lines != ref_lines);

  assign in_window = (h_cnt >= X_LO) && (h_cnt < X_HI) &&
                     (v_cnt >= Y_LO) && (v_cnt < Y_HI);
  assign pix_valid = (state == LOCKED) && in_window;

  // ---------------------------------------------------------------------------
  // Lock FSM: next state and measurement bookkeeping
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves a value unassigned and no latch can be inferred.
  always_comb begin
    state_next     = state;
    ref_len_next   = ref_len;
    ref_lines_next = ref_lines;
    have_ref_next  = have_ref;
    bad_next       = bad;
    lock_loss      = 1'b0;

    case (state)
      SEARCH: begin
        // A stuck H sync keeps us here even if V keeps toggling.
        if (!h_sat && v_edge) begin
          state_next    = MEASURE;
          have_ref_next = 1'b0;
          bad_next      = 1'b0;
        end
      end

      MEASURE: begin
        if (h_sat) begin
          state_next = SEARCH;
        end else if (v_edge) begin
          // A coincident H edge closes the last line of the measured frame,
          // so its length still takes part in the decision.
          if (!bad && !(h_edge && have_ref && len_mismatch) &&
              (frame_lines >= MIN_LINES)) begin
            state_next     = LOCKED;
            ref_lines_next = frame_lines;
          end
          // Whether locking or restarting, the next measurement starts clean.
          have_ref_next = 1'b0;
          bad_next      = 1'b0;
        end else if (h_edge) begin
          if (!have_ref) begin
            ref_len_next  = line_len;
            have_ref_next = 1'b1;
          end else if (len_mismatch) begin
            bad_next = 1'b1;
          end
        end
      end

      LOCKED: begin
        if (h_sat || (h_edge && len_mismatch) || (v_edge && lines_mismatch)) begin
          lock_loss  = 1'b1;
          state_next = SEARCH;
        end
      end

      default: state_next = SEARCH;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Timing state: sync history, counters, FSM and references
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, independent of code order.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state     <= SEARCH;
      h_prev    <= 1'b1;
      v_prev    <= 1'b1;
      h_cnt     <= '0;
      v_cnt     <= '0;
      ref_len   <= '0;
      ref_lines <= '0;
      have_ref  <= 1'b0;
      bad       <= 1'b0;
    end else begin
      state     <= state_next;
      h_prev    <= iVGA_H_SYNC;
      v_prev    <= iVGA_V_SYNC;
      ref_len   <= ref_len_next;
      ref_lines <= ref_lines_next;
      have_ref  <= have_ref_next;
      bad       <= bad_next;

      if (h_edge) begin
        h_cnt <= '0;
      end else if (!h_sat) begin
        h_cnt <= h_cnt + CNT_ONE;
      end

      // V edge takes priority over a simultaneous H edge.
      if (v_edge) begin
        v_cnt <= '0;
      end else if (h_edge && (v_cnt != CNT_MAX)) begin
        v_cnt <= v_cnt + CNT_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      oPix_Valid   <= 1'b0;
      oX           <= '0;
      oY           <= '0;
      oR           <= '0;
      oG           <= '0;
      oB           <= '0;
      oFrame_Start <= 1'b0;
      oLocked      <= 1'b0;
      oErr         <= 1'b0;
      oLine_Len    <= '0;
      oFrame_Lines <= '0;
    end else begin
      oPix_Valid   <= pix_valid;
      oFrame_Start <= pix_valid && (h_cnt == X_LO) && (v_cnt == Y_LO);
      // Tracking state_next makes oLocked fall together with the oErr pulse.
      oLocked      <= (state_next == LOCKED);
      oErr         <= lock_loss;

      // Coordinates and colour only move inside the window; outside they hold.
      if (in_window) begin
        oX <= h_cnt - X_LO;
        oY <= v_cnt - Y_LO;
        oR <= iVGA_R;
        oG <= iVGA_G;
        oB <= iVGA_B;
      end

      if (h_edge) begin
        oLine_Len <= line_len;
      end
      if (v_edge) begin
        oFrame_Lines <= frame_lines;
      end
    end
  end

`ifdef VGA_SYNC_RECEIVER_STATS_EN
  // ---------------------------------------------------------------------------
  // Statistics: locked frames (wrapping) and lock losses (saturating)
  // ---------------------------------------------------------------------------
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      oFrame_Cnt <= '0;
      oErr_Cnt   <= '0;
    end else begin
      if ((state == LOCKED) && v_edge) begin
        oFrame_Cnt <= oFrame_Cnt + 16'd1;
      end
      if (lock_loss && (oErr_Cnt != 16'hFFFF)) begin
        oErr_Cnt <= oErr_Cnt + 16'd1;
      end
    end
  end
`endif

endmodule
